// File: rtl/axi_llc_burst_splitter.sv
// -----------------------------------------------------------------------------
// axi_llc_burst_splitter
//
// Purpose:
//   Accepts one AXI AW/AR transaction, holds it, and emits one LLC descriptor
//   per cache-line-bounded fragment. Fragments are also capped at MaxDescBeats.
//   Each fragment is decoded on its own against the cached region and the
//   per-way SPM regions. WRAP bursts that do not fit in one line are rejected
//   with SLVERR.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   ax_chan_i           incoming AW/AR channel payload
//   ax_valid_i/ready_o  input handshake (ready only while idle)
//   desc_o              current fragment descriptor (all zero while idle)
//   desc_valid_o/ready_i output handshake
//   cached_rule_i       cached region [start_addr, end_addr)
//   spm_rule_i          SPM base (start_addr only); way w owns one slice
//   busy_o              a transaction is currently held
// -----------------------------------------------------------------------------
package axi_llc_burst_splitter_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned NumWays   = 4;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
    } chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   a_x_id;
        logic [AddrWidth-1:0] a_x_addr;
        logic [7:0]           a_x_len;
        logic [2:0]           a_x_size;
        logic [1:0]           a_x_burst;
        logic                 a_x_lock;
        logic [3:0]           a_x_cache;
        logic [2:0]           a_x_prot;
        logic [1:0]           x_resp;
        logic                 x_last;
        logic                 rw;
        logic [NumWays-1:0]   way_ind;
        logic                 spm;
    } desc_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } rule_t;
endpackage

module axi_llc_burst_splitter
    import axi_llc_burst_splitter_pkg::*;
#(
    parameter int unsigned ByteOffsetLength  = 3,
    parameter int unsigned BlockOffsetLength = 3,
    parameter int unsigned BlockSize         = 64,
    parameter int unsigned NumBlocks         = 8,
    parameter int unsigned NumLines          = 64,
    parameter int unsigned MaxDescBeats      = 256,
    parameter bit          Write             = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  chan_t ax_chan_i,
    input  logic  ax_valid_i,
    output logic  ax_ready_o,
    output desc_t desc_o,
    output logic  desc_valid_o,
    input  logic  desc_ready_i,
    input  rule_t cached_rule_i,
    input  rule_t spm_rule_i,
    output logic  busy_o
);
    localparam int unsigned A        = AddrWidth;
    localparam int unsigned LineOffW = ByteOffsetLength + BlockOffsetLength;
    localparam logic [63:0] WayBytes = 64'(BlockSize / 8 * NumBlocks * NumLines);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e      state_q, state_d;
    chan_t       cur_q, cur_d;
    logic [8:0]  rem_q, rem_d;

    // ---------------- fragment geometry ----------------
    logic [A-1:0] line_bytes, line_mask, next_line, line_dist, line_beats_w;
    logic [A-1:0] size_mask, addr_aligned, addr_next;
    logic [8:0]   rem_p1, line_beats_sat, beats, beats_m1;
    logic [31:0]  wrap_bytes;
    logic         wrap_fits;

    assign line_bytes = {{(A-1){1'b0}}, 1'b1} << LineOffW;
    assign line_mask  = line_bytes - 1'b1;
    assign next_line  = (cur_q.addr & ~line_mask) + line_bytes;
    // Distance to the next line boundary is at most L, so this is a small value
    // even when next_line wraps past the top of the address space.
    assign line_dist    = next_line - cur_q.addr;
    assign line_beats_w = ((line_dist - 1'b1) >> cur_q.size) + 1'b1;

    // MaxDescBeats <= 256, so clamping to it also keeps the result in 9 bits.
    assign line_beats_sat = (line_beats_w > A'(MaxDescBeats)) ? 9'(MaxDescBeats)
                                                              : line_beats_w[8:0];
    assign rem_p1   = rem_q + 9'd1;
    assign beats    = (line_beats_sat < rem_p1) ? line_beats_sat : rem_p1;
    assign beats_m1 = beats - 9'd1;

    assign size_mask    = ({{(A-1){1'b0}}, 1'b1} << cur_q.size) - 1'b1;
    assign addr_aligned = cur_q.addr & ~size_mask;
    assign addr_next    = addr_aligned + (A'(beats) << cur_q.size);

    assign wrap_bytes = (32'(cur_q.len) + 32'd1) << cur_q.size;
    assign wrap_fits  = wrap_bytes <= (32'd1 << LineOffW);

    // ---------------- address decode ----------------
    logic [63:0]        addr_ext;
    logic               cached_hit;
    logic [NumWays-1:0] spm_hit, spm_onehot;

    assign addr_ext   = 64'(cur_q.addr);
    assign cached_hit = (addr_ext >= cached_rule_i.start_addr) &&
                        (addr_ext <  cached_rule_i.end_addr);

    generate
        for (genvar gi = 0; gi < NumWays; gi++) begin : g_spm_way
            logic [63:0] way_lo;
            assign way_lo      = spm_rule_i.start_addr + 64'(gi) * WayBytes;
            assign spm_hit[gi] = (addr_ext >= way_lo) && (addr_ext < way_lo + WayBytes);
        end
    endgenerate

    // Ways are disjoint; isolating the lowest set bit only matters if the SPM
    // window wraps around the address space.
    assign spm_onehot = spm_hit & (~spm_hit + 1'b1);

    logic unused_rule_bits;
    assign unused_rule_bits = ^{cached_rule_i.idx, spm_rule_i.idx, spm_rule_i.end_addr};

    // ---------------- fragment descriptor ----------------
    desc_t frag;
    logic  frag_last;

    always_comb begin
        frag           = '0;
        frag.a_x_id    = cur_q.id;
        frag.a_x_addr  = cur_q.addr;
        frag.a_x_size  = cur_q.size;
        frag.a_x_burst = cur_q.burst;
        frag.a_x_lock  = cur_q.lock;
        frag.a_x_cache = cur_q.cache;
        frag.a_x_prot  = cur_q.prot;
        frag.rw        = Write;

        if (cached_hit) begin
            frag.spm     = 1'b0;
            frag.way_ind = '0;
            frag.x_resp  = RespOkay;
        end else if (|spm_hit) begin
            frag.spm     = 1'b1;
            frag.way_ind = spm_onehot;
            frag.x_resp  = RespOkay;
        end else begin
            frag.spm     = 1'b1;
            frag.way_ind = NumWays'(1);
            frag.x_resp  = RespSlvErr;
        end

        case (cur_q.burst)
            BurstFixed: begin
                frag.a_x_len = rem_q[7:0];
                frag_last    = 1'b1;
            end
            BurstWrap: begin
                frag.a_x_len = rem_q[7:0];
                frag_last    = 1'b1;
                // A wrap that spans more than one line cannot be served.
                if (!wrap_fits) begin
                    frag.spm     = 1'b1;
                    frag.way_ind = NumWays'(1);
                    frag.x_resp  = RespSlvErr;
                end
            end
            default: begin
                frag.a_x_len = beats_m1[7:0];
                frag_last    = (beats == rem_p1);
            end
        endcase
        frag.x_last = frag_last;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        ax_ready_o   = 1'b0;
        desc_valid_o = 1'b0;
        busy_o       = 1'b0;
        desc_o       = '0;
        case (state_q)
            IDLE: begin
                ax_ready_o = 1'b1;
                if (ax_valid_i) begin
                    cur_d   = ax_chan_i;
                    rem_d   = {1'b0, ax_chan_i.len};
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                desc_valid_o = 1'b1;
                busy_o       = 1'b1;
                desc_o       = frag;
                if (desc_ready_i) begin
                    if (frag_last) begin
                        state_d = IDLE;
                    end else begin
                        cur_d.addr = addr_next;
                        rem_d      = rem_q - beats;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_llc_burst_splitter.sv
module tb_axi_llc_burst_splitter;
    import axi_llc_burst_splitter_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    chan_t ax_chan = '0;
    logic  ax_valid = 1'b0;
    logic  ax_ready;
    desc_t desc;
    logic  desc_valid;
    logic  desc_ready = 1'b1;
    rule_t cached_rule;
    rule_t spm_rule;
    logic  busy;

    int total  = 0;
    int passed = 0;

    desc_t exp_q[$];

    always #5 clk = ~clk;

    axi_llc_burst_splitter #(
        .ByteOffsetLength (3),
        .BlockOffsetLength(3),
        .BlockSize        (64),
        .NumBlocks        (8),
        .NumLines         (64),
        .MaxDescBeats     (8),
        .Write            (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ax_chan_i    (ax_chan),
        .ax_valid_i   (ax_valid),
        .ax_ready_o   (ax_ready),
        .desc_o       (desc),
        .desc_valid_o (desc_valid),
        .desc_ready_i (desc_ready),
        .cached_rule_i(cached_rule),
        .spm_rule_i   (spm_rule),
        .busy_o       (busy)
    );

    task automatic check(input bit ok, input string name, input string info);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, info);
    endtask

    function automatic chan_t mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
        chan_t c;
        c       = '0;
        c.id    = id;
        c.addr  = addr;
        c.len   = len;
        c.size  = size;
        c.burst = burst;
        c.lock  = 1'b0;
        c.cache = 4'b0011;
        c.prot  = 3'b010;
        return c;
    endfunction

    function automatic desc_t mk_desc(input chan_t c, input logic [31:0] addr,
                                      input logic [7:0] len, input logic last,
                                      input logic spm, input logic [3:0] way,
                                      input logic [1:0] resp);
        desc_t d;
        d           = '0;
        d.a_x_id    = c.id;
        d.a_x_addr  = addr;
        d.a_x_len   = len;
        d.a_x_size  = c.size;
        d.a_x_burst = c.burst;
        d.a_x_lock  = c.lock;
        d.a_x_cache = c.cache;
        d.a_x_prot  = c.prot;
        d.x_resp    = resp;
        d.x_last    = last;
        d.rw        = 1'b1;
        d.way_ind   = way;
        d.spm       = spm;
        return d;
    endfunction

    // Monitor: each handshake is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && desc_valid && desc_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_desc", $sformatf("got %h, expected none", desc));
            end else begin
                desc_t e;
                e = exp_q.pop_front();
                check(desc === e, "desc",
                      $sformatf("got %h required %h", desc, e));
                $display("desc id=%0d addr=%h len=%0d last=%0b spm=%0b way=%b resp=%0d",
                         desc.a_x_id, desc.a_x_addr, desc.a_x_len, desc.x_last,
                         desc.spm, desc.way_ind, desc.x_resp);
            end
        end
    end

    task automatic send(input chan_t c);
        int n;
        n = 0;
        @(negedge clk);
        while (!ax_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ax_ready) check(1'b0, "ax_ready_timeout", "ax_ready_o never rose");
        ax_chan  = c;
        ax_valid = 1'b1;
        @(posedge clk);
        #1;
        ax_valid = 1'b0;
        check(desc_valid === 1'b1, "first_latency",
              $sformatf("desc_valid_o=%b required 1", desc_valid));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(!busy, "idle_timeout", $sformatf("busy_o=%b required 0", busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chan_t c1, c2, c3a, c3b, c4a, c4b, c4c;
        desc_t hold;

        cached_rule            = '0;
        cached_rule.start_addr = 64'h8000_0000;
        cached_rule.end_addr   = 64'h9000_0000;
        spm_rule               = '0;
        spm_rule.start_addr    = 64'h1000_0000;
        spm_rule.end_addr      = 64'h1000_4000;

        c1  = mk_ax(4'd1, 32'h8000_0030, 8'd9,   3'd3, 2'b01);
        c2  = mk_ax(4'd2, 32'h8000_0000, 8'd19,  3'd0, 2'b01);
        c3a = mk_ax(4'd3, 32'h1000_2010, 8'd0,   3'd2, 2'b01);
        c3b = mk_ax(4'd4, 32'h0000_0100, 8'd0,   3'd2, 2'b01);
        c4a = mk_ax(4'd5, 32'h8000_0018, 8'd7,   3'd3, 2'b10);
        c4b = mk_ax(4'd6, 32'h8000_0000, 8'd15,  3'd3, 2'b10);
        c4c = mk_ax(4'd7, 32'h8000_0100, 8'd200, 3'd2, 2'b00);

        // Reset state
        repeat (2) @(negedge clk);
        check(ax_ready === 1'b1 && desc_valid === 1'b0 && busy === 1'b0,
              "reset_ctrl", $sformatf("ready=%b valid=%b busy=%b required 1/0/0",
                                       ax_ready, desc_valid, busy));
        check(desc === '0, "reset_desc", $sformatf("got %h required 0", desc));
        rst = 1'b0;

        // 1: line-bounded INCR split
        exp_q.push_back(mk_desc(c1, 32'h8000_0030, 8'd1, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c1, 32'h8000_0040, 8'd7, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c1);
        wait_idle();

        // 2: beat cap
        exp_q.push_back(mk_desc(c2, 32'h8000_0000, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0008, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0010, 8'd3, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c2);
        wait_idle();

        // 3: SPM way 2 and decode miss
        exp_q.push_back(mk_desc(c3a, 32'h1000_2010, 8'd0, 1'b1, 1'b1, 4'b0100, 2'b00));
        send(c3a);
        wait_idle();
        exp_q.push_back(mk_desc(c3b, 32'h0000_0100, 8'd0, 1'b1, 1'b1, 4'b0001, 2'b10));
        send(c3b);
        wait_idle();

        // 4: WRAP fit, WRAP reject, FIXED uncapped
        exp_q.push_back(mk_desc(c4a, 32'h8000_0018, 8'd7, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c4a);
        wait_idle();
        exp_q.push_back(mk_desc(c4b, 32'h8000_0000, 8'd15, 1'b1, 1'b1, 4'b0001, 2'b10));
        send(c4b);
        wait_idle();
        exp_q.push_back(mk_desc(c4c, 32'h8000_0100, 8'd200, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c4c);
        wait_idle();

        // 5: backpressure, then back-to-back acceptance after one bubble
        desc_ready = 1'b0;
        exp_q.push_back(mk_desc(c1, 32'h8000_0030, 8'd1, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c1, 32'h8000_0040, 8'd7, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c1);
        hold = desc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(desc === hold && desc_valid === 1'b1 && ax_ready === 1'b0,
                  "backpressure_hold",
                  $sformatf("cyc %0d desc=%h valid=%b ready=%b required %h/1/0",
                            i, desc, desc_valid, ax_ready, hold));
        end
        @(posedge clk);
        #1;
        desc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check(desc.x_last === 1'b1 && ax_ready === 1'b0, "last_frag_ready",
              $sformatf("last=%b ax_ready=%b required 1/0", desc.x_last, ax_ready));
        @(posedge clk);
        #1;
        check(ax_ready === 1'b1, "bubble_ready",
              $sformatf("ax_ready_o=%b required 1", ax_ready));
        exp_q.push_back(mk_desc(c3a, 32'h1000_2010, 8'd0, 1'b1, 1'b1, 4'b0100, 2'b00));
        ax_chan  = c3a;
        ax_valid = 1'b1;
        @(posedge clk);
        #1;
        ax_valid = 1'b0;
        check(busy === 1'b1, "accept_after_bubble",
              $sformatf("busy_o=%b required 1", busy));
        wait_idle();

        // 6: reset mid-burst
        exp_q.push_back(mk_desc(c2, 32'h8000_0000, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0008, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0010, 8'd3, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check(desc_valid === 1'b0 && ax_ready === 1'b1 && busy === 1'b0, "async_reset",
              $sformatf("valid=%b ready=%b busy=%b required 0/1/0",
                        desc_valid, ax_ready, busy));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk_desc(c2, 32'h8000_0000, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0008, 8'd7, 1'b0, 1'b0, 4'b0000, 2'b00));
        exp_q.push_back(mk_desc(c2, 32'h8000_0010, 8'd3, 1'b1, 1'b0, 4'b0000, 2'b00));
        send(c2);
        wait_idle();

        repeat (2) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_drained",
              $sformatf("%0d expected descriptors left, required 0", exp_q.size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
